// File: rtl/led_seq_pkg.sv
// Shared types and constants for the plights LED pattern sequencer.
package led_seq_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] LED_INIT       = 8'h01;
  localparam logic [LED_W-1:0] LED_INIT_BLINK = 8'hFF;
  localparam logic [LED_W-1:0] LED_ALL_ON     = 8'hFF;
  localparam logic [LED_W-1:0] LED_TOP        = 8'h80;
  localparam logic [LED_W-1:0] LED_BOTTOM     = 8'h01;

  // Pattern loaded whenever a mode is entered.
  function automatic logic [LED_W-1:0] init_pattern(mode_e m);
    return (m == MODE_BLINK) ? LED_INIT_BLINK : LED_INIT;
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-tick prescaler: counts 0..DIV-1 while enabled, tick on the last count.
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/led_seq_ctrl.sv
// Running-light sequencer for the 8-LED bank: prescaled steps, manual and auto mode advance.
// Define LED_SEQ_BLINK_EN to include the BLINK mode (otherwise modes wrap after FILL).
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned DIV            = 2,
  parameter int unsigned STEPS_PER_MODE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             next_req,
  input  logic             auto_adv,
  output logic [LED_W-1:0] led,
  output logic             step_tick,
  output logic [1:0]       mode
);

  localparam int unsigned SC_W = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STEPS_PER_MODE - 1);

  logic             r_req_sync;
  logic             r_req_prev;
  mode_e            r_mode;
  logic [LED_W-1:0] r_led;
  logic             r_dir_up;
  logic [SC_W-1:0]  r_step_cnt;
  logic             r_step_tick;

  logic             w_req;
  logic             w_step;
  mode_e            w_mode_adv;
  mode_e            w_mode_nxt;
  logic [LED_W-1:0] w_led_nxt;
  logic             w_dir_nxt;
  logic [SC_W-1:0]  w_cnt_nxt;
  logic             w_tick_nxt;
  logic [LED_W-1:0] w_pat_nxt;
  logic             w_pat_dir;

  function automatic mode_e advance_mode(mode_e m);
`ifdef LED_SEQ_BLINK_EN
    return mode_e'(2'(2'(m) + 2'd1));
`else
    return (m == MODE_FILL) ? MODE_RUN : mode_e'(2'(2'(m) + 2'd1));
`endif
  endfunction

  assign w_req = r_req_sync & ~r_req_prev;

  led_seq_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .i_en     (en),
    .i_clr    (w_req),
    .o_tick_c (w_step)
  );

  // Next LED value for an ordinary pattern step in the current mode.
  always_comb begin
    w_pat_nxt = r_led;
    w_pat_dir = r_dir_up;
    case (r_mode)
      MODE_RUN:    w_pat_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
      MODE_BOUNCE: begin
        if (r_dir_up) begin
          if (r_led == LED_TOP) begin
            w_pat_nxt = {1'b0, r_led[LED_W-1:1]};
            w_pat_dir = 1'b0;
          end else begin
            w_pat_nxt = {r_led[LED_W-2:0], 1'b0};
          end
        end else begin
          if (r_led == LED_BOTTOM) begin
            w_pat_nxt = {r_led[LED_W-2:0], 1'b0};
            w_pat_dir = 1'b1;
          end else begin
            w_pat_nxt = {1'b0, r_led[LED_W-1:1]};
          end
        end
      end
      MODE_FILL:   w_pat_nxt = (r_led == LED_ALL_ON) ? '0 : {r_led[LED_W-2:0], 1'b1};
`ifdef LED_SEQ_BLINK_EN
      MODE_BLINK:  w_pat_nxt = ~r_led;
`endif
      default: ;
    endcase
  end

  // Manual request outranks any step; an auto-advance step replaces the pattern step.
  always_comb begin
    w_mode_adv = advance_mode(r_mode);
    w_mode_nxt = r_mode;
    w_led_nxt  = r_led;
    w_dir_nxt  = r_dir_up;
    w_cnt_nxt  = r_step_cnt;
    w_tick_nxt = 1'b0;
    if (w_req) begin
      w_mode_nxt = w_mode_adv;
      w_led_nxt  = init_pattern(w_mode_adv);
      w_dir_nxt  = 1'b1;
      w_cnt_nxt  = '0;
    end else if (w_step) begin
      w_tick_nxt = 1'b1;
      if (auto_adv && (r_step_cnt == SC_MAX)) begin
        w_mode_nxt = w_mode_adv;
        w_led_nxt  = init_pattern(w_mode_adv);
        w_dir_nxt  = 1'b1;
        w_cnt_nxt  = '0;
      end else begin
        w_led_nxt = w_pat_nxt;
        w_dir_nxt = w_pat_dir;
        if (r_step_cnt != SC_MAX) begin
          w_cnt_nxt = r_step_cnt + SC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_sync  <= 1'b0;
      r_req_prev  <= 1'b0;
      r_mode      <= MODE_RUN;
      r_led       <= LED_INIT;
      r_dir_up    <= 1'b1;
      r_step_cnt  <= '0;
      r_step_tick <= 1'b0;
    end else begin
      r_req_sync  <= next_req;
      r_req_prev  <= r_req_sync;
      r_mode      <= w_mode_nxt;
      r_led       <= w_led_nxt;
      r_dir_up    <= w_dir_nxt;
      r_step_cnt  <= w_cnt_nxt;
      r_step_tick <= w_tick_nxt;
    end
  end

  assign led       = r_led;
  assign step_tick = r_step_tick;
  assign mode      = r_mode;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: two instances (DIV=2/SPM=4 and DIV=1/SPM=3) against a phase-index model.
module tb_led_seq_ctrl;

`ifdef LED_SEQ_BLINK_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       next_req;
  logic       auto_adv;
  logic [7:0] led_w  [2];
  logic       tick_w [2];
  logic [1:0] mode_w [2];

  int n_checks = 0;
  int n_errors = 0;

  int divs [2] = '{2, 1};
  int spms [2] = '{4, 3};

  int m_pc    [2];
  int m_sc    [2];
  int m_mode  [2];
  int m_phase [2];
  bit m_tick  [2];
  bit m_sync  [2];
  bit m_prev  [2];

  led_seq_ctrl #(.DIV(2), .STEPS_PER_MODE(4)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .next_req(next_req), .auto_adv(auto_adv),
    .led(led_w[0]), .step_tick(tick_w[0]), .mode(mode_w[0])
  );

  led_seq_ctrl #(.DIV(1), .STEPS_PER_MODE(3)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .next_req(next_req), .auto_adv(auto_adv),
    .led(led_w[1]), .step_tick(tick_w[1]), .mode(mode_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // LED value as a function of mode and number of steps since mode entry.
  function automatic logic [7:0] pat(input int md, input int ph);
    int p;
    case (md)
      0: return 8'(1 << (ph % 8));
      1: begin
        p = ph % 14;
        return (p < 8) ? 8'(1 << p) : 8'(1 << (14 - p));
      end
      2: begin
        p = ph % 9;
        return (p < 8) ? 8'((2 << p) - 1) : 8'h00;
      end
      default: return ((ph % 2) == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_sc[i] = 0; m_mode[i] = 0; m_phase[i] = 0;
      m_tick[i] = 0; m_sync[i] = 0; m_prev[i] = 0;
    end
  endtask

  task automatic enter_next_mode(input int i);
    m_mode[i]  = (m_mode[i] + 1) % NMODES;
    m_phase[i] = 0;
    m_sc[i]    = 0;
  endtask

  task automatic model_step();
    bit req;
    bit stp;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        req = m_sync[i] && !m_prev[i];
        stp = en && (m_pc[i] == divs[i] - 1);
        m_prev[i] = m_sync[i];
        m_sync[i] = next_req;
        if (req) begin
          enter_next_mode(i);
          m_pc[i]   = 0;
          m_tick[i] = 0;
        end else begin
          if (en) m_pc[i] = (m_pc[i] + 1) % divs[i];
          m_tick[i] = stp;
          if (stp) begin
            if (auto_adv && m_sc[i] == spms[i] - 1) begin
              enter_next_mode(i);
            end else begin
              m_phase[i]++;
              if (m_sc[i] < spms[i] - 1) m_sc[i]++;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("led%0d", i),  32'(led_w[i]),  32'(pat(m_mode[i], m_phase[i])));
      chk($sformatf("mode%0d", i), 32'(mode_w[i]), 32'(m_mode[i]));
      chk($sformatf("tick%0d", i), 32'(tick_w[i]), 32'(m_tick[i]));
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    tick_clk();
    rst = 1'b0;
  endtask

  logic [7:0] bexp [16];
  int nb;
  int exp_mode;
  logic [7:0] frz_led;

  initial begin
    bexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    rst = 1'b1; en = 1'b0; next_req = 1'b0; auto_adv = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_led", 32'(led_w[0]), 32'h01);
    chk("rst_mode", 32'(mode_w[0]), 32'h0);
    chk("rst_tick", 32'(tick_w[0]), 32'h0);

    // Basic stepping
    rst = 1'b0; en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick_clk();
      if (c == 1)  chk("basic_c1", 32'(led_w[0]), 32'h01);
      if (c == 2)  chk("basic_c2", 32'(led_w[0]), 32'h02);
      if (c == 2)  chk("basic_tick", 32'(tick_w[0]), 32'h1);
      if (c == 16) chk("basic_wrap", 32'(led_w[0]), 32'h01);
    end

    // Manual advance, four pulses
    for (int p = 0; p < 4; p++) begin
      exp_mode = (p + 1) % NMODES;
      next_req = 1'b1;
      tick_clk();
      chk("man_latency", 32'(mode_w[0]), 32'(p % NMODES));
      tick_clk();
      chk("man_mode", 32'(mode_w[0]), 32'(exp_mode));
      chk("man_led", 32'(led_w[0]), (exp_mode == 3) ? 32'hFF : 32'h01);
      chk("man_tick", 32'(tick_w[0]), 32'h0);
      next_req = 1'b0;
      repeat (3) tick_clk();
    end

    // BOUNCE reversal
    reset_pulse();
    next_req = 1'b1;
    repeat (2) tick_clk();
    next_req = 1'b0;
    chk("bounce_mode", 32'(mode_w[0]), 32'h1);
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      tick_clk();
      if (tick_w[0] && nb < 16) begin
        chk($sformatf("bounce_%0d", nb), 32'(led_w[0]), 32'(bexp[nb]));
        nb++;
      end
    end
    chk("bounce_count", 32'(nb), 32'd16);

    // Auto advance
    reset_pulse();
    auto_adv = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick_clk();
      if (c == 6) chk("auto_led3", 32'(led_w[0]), 32'h08);
      if (c == 6) chk("auto_mode3", 32'(mode_w[0]), 32'h0);
      if (c == 8) chk("auto_mode", 32'(mode_w[0]), 32'h1);
      if (c == 8) chk("auto_led", 32'(led_w[0]), 32'h01);
      if (c == 8) chk("auto_tick", 32'(tick_w[0]), 32'h1);
    end

    // Manual request colliding with an auto-advance step
    reset_pulse();
    for (int c = 1; c <= 14; c++) begin
      if (c == 7) next_req = 1'b1;
      if (c == 9) next_req = 1'b0;
      tick_clk();
      if (c == 8) chk("coll_mode", 32'(mode_w[0]), 32'h1);
      if (c == 8) chk("coll_tick", 32'(tick_w[0]), 32'h0);
      if (c == 8) chk("coll_led", 32'(led_w[0]), 32'h01);
    end

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ((c % 50) == 0) auto_adv = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) next_req = ~next_req;
      tick_clk();
    end

    // Freeze with en low
    next_req = 1'b0; en = 1'b1;
    repeat (3) tick_clk();
    en = 1'b0;
    frz_led = pat(m_mode[0], m_phase[0]);
    for (int c = 0; c < 10; c++) begin
      tick_clk();
      chk("freeze_led", 32'(led_w[0]), 32'(frz_led));
      chk("freeze_tick", 32'(tick_w[0]), 32'h0);
    end
    en = 1'b1;
    next_req = 1'b1;
    repeat (5) tick_clk();

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_led%0d", i),  32'(led_w[i]),  32'h01);
      chk($sformatf("arst_mode%0d", i), 32'(mode_w[i]), 32'h0);
      chk($sformatf("arst_tick%0d", i), 32'(tick_w[i]), 32'h0);
    end
    @(negedge clk);
    check_all();
    rst = 1'b0; next_req = 1'b0;
    repeat (10) tick_clk();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer for the 8-LED bank on the plights board. Divides the system clock into step ticks and generates one of several running-light patterns on each tick. Switches patterns on a user request or automatically after a fixed number of steps. Sits between the board clock/reset and the `led` pins as the sole driver of the bank.

## Interface
- `DIV`, 2: clock cycles per step tick; must be at least 1.
- `STEPS_PER_MODE`, 16: steps before auto-advance; must be at least 1.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: level input; freezes the prescaler and pattern when low.
- `next_req` in 1: level input; each rising edge requests one mode advance.
- `auto_adv` in 1: level input; enables automatic mode advance.
- `led` out 8: LED bank drive, registered.
- `step_tick` out 1: one-cycle pulse, coincident with each `led` update.
- `mode` out 2: current pattern mode, registered.

## Operation
- Reset values:
  - `led` = 8'h01, `mode` = RUN (0), `step_tick` = 0.
  - Prescaler, step counter and `next_req` history = 0.
  - BOUNCE direction = up.
- Prescaler:
  - While `en`=1, counts 0..DIV-1 and wraps.
  - A step fires when count = DIV-1 and `en`=1.
  - While `en`=0, the count holds.
- Patterns, advanced once per step:
  - RUN (0): 01→02→…→80→01. Rotate left.
  - BOUNCE (1): 01→02→…→80→40→…→01→02. Direction flips on reaching 80 (to down) and 01 (to up); period 14.
  - FILL (2): 01→03→07→…→FF→00→01. Period 9.
  - BLINK (3): FF↔00.
- Initial pattern on mode entry:
  - RUN, BOUNCE, FILL: 01. BOUNCE direction also resets to up.
  - BLINK: FF.
- Manual advance:
  - `next_req` is registered once; a rising edge of the registered value is a request.
  - On a request: `mode` advances with wrap, `led` loads the new mode's initial pattern, prescaler and step counter clear, `step_tick` = 0.
  - Honoured regardless of `en`.
- Auto advance:
  - The step counter counts steps taken in the current mode.
  - When `auto_adv`=1 and a step fires with step counter = STEPS_PER_MODE-1, that step is a mode advance instead of a pattern step.
  - `step_tick` still pulses; `led` loads the new initial pattern; step counter clears.
  - With `auto_adv`=0, the step counter saturates at STEPS_PER_MODE-1.
- Simultaneous events:
  - Manual request and step in the same cycle: manual path wins; exactly one mode advance; no `step_tick`.
  - Manual request and auto-advance step in the same cycle: exactly one mode advance.
- Reset mid-pattern: all state returns to reset values asynchronously; no partial step completes.

## Timing
- All outputs are registered. `led`, `mode` and `step_tick` change on the same edge.
- First `led` change after reset release with `en`=1: DIV edges.
- Step period: DIV cycles; `step_tick` high for exactly 1 cycle per step.
- DIV=1: `step_tick` is held high continuously while `en`=1; `led` steps every cycle.
- Manual advance latency: 2 edges from `next_req` rising (1 edge for the sync register, 1 edge for the update).
- `en` deassertion takes effect at the next edge; no step fires on that edge.

## Configuration
- `LED_SEQ_BLINK_EN` defined:
  - All four modes are present; `mode` wraps 3→0.
- `LED_SEQ_BLINK_EN` undefined:
  - BLINK logic is omitted; `mode` wraps 2→0 and never takes value 3.
  - All other behaviour is unchanged.

## Structure
- Package `led_seq_pkg` holds:
  - Mode encodings RUN/BOUNCE/FILL/BLINK (2-bit).
  - Initial-pattern constants.
  - LED width constant (8).
- Sub-module `led_seq_prescaler` contains the DIV counter with enable and clear inputs and a tick output. All other logic is in `led_seq_ctrl`.

## Test plan
- Basic stepping:
  - Stimulus: DIV=2, `en`=1, `auto_adv`=0; release reset.
  - Response: `led` = 01, 02, 04, … 80, 01; changes every 2 cycles; `step_tick` pulses on each change; `mode` stays 0.
- Manual advance:
  - Stimulus: pulse `next_req` four times.
  - Response: `mode` 0→1→2→3→0.
  - `led` loads 01, 01, FF, 01 on entry to modes 1, 2, 3, 0 respectively.
  - Without `LED_SEQ_BLINK_EN`: `mode` goes 0→1→2→0.
- BOUNCE reversal:
  - Stimulus: mode 1, 16 steps.
  - Response: 01 02 04 08 10 20 40 80 40 20 10 08 04 02 01 02.
- Auto advance:
  - Stimulus: STEPS_PER_MODE=4, `auto_adv`=1.
  - Response in RUN: 01, 02, 04, 08, then the 4th step sets `mode`=1 and `led`=01.
- Collision:
  - Stimulus: `next_req` rising timed so its update edge coincides with an auto-advance step.
  - Response: `mode` increments by exactly 1; `step_tick` = 0 on that edge.
- Freeze and async reset:
  - Stimulus: `en`=0 for 10 cycles, then assert `rst` mid-step.
  - Response: `led` and `step_tick` hold during `en`=0.
  - On `rst`, all outputs return to reset values immediately, without waiting for a clock edge: `led`=01, `mode`=0, `step_tick`=0.
